// File: rtl/framebuffer_fill_ctrl.sv
// Frame buffer write-port arbiter: CPU pixel stores win, a rectangle fill engine uses free cycles.
// Build option FILL_ABORT_EN adds a fill_abort input that ends a running fill early.
module framebuffer_fill_ctrl #(
  parameter int WIDTH        = 160,
  parameter int HEIGHT       = 120,
  parameter int BITSPERPIXEL = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              cpu_x,
  input  logic [7:0]              cpu_y,
  input  logic [BITSPERPIXEL-1:0] cpu_color,
  input  logic                    cpu_write,
  input  logic                    fill_start,
  input  logic [7:0]              fill_x0,
  input  logic [7:0]              fill_y0,
  input  logic [7:0]              fill_x1,
  input  logic [7:0]              fill_y1,
  input  logic [BITSPERPIXEL-1:0] fill_color,
`ifdef FILL_ABORT_EN
  input  logic                    fill_abort,
`endif
  output logic                    fill_busy,
  output logic                    fill_done,
  output logic [7:0]              fb_x,
  output logic [7:0]              fb_y,
  output logic [BITSPERPIXEL-1:0] fb_color,
  output logic                    fb_write
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [7:0] YMAX = 8'(HEIGHT - 1);

  logic [1:0]              state;
  logic [7:0]              x0_reg, x1c, y1c, cur_x, cur_y;
  logic [BITSPERPIXEL-1:0] color_reg;
  logic                    abort, issue, last, empty;

`ifdef FILL_ABORT_EN
  assign abort = fill_abort && (state == FILL);
`else
  assign abort = 1'b0;
`endif

  // A fill pixel only goes out on a cycle the CPU leaves free.
  assign issue = (state == FILL) && !cpu_write && !abort;
  assign last  = (cur_x == x1c) && (cur_y == y1c);
  assign empty = (fill_x0 > fill_x1) || (fill_y0 > fill_y1) ||
                 (fill_x0 > XMAX) || (fill_y0 > YMAX);

  assign fill_busy = (state == FILL);
  assign fill_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x0_reg    <= '0;
      x1c       <= '0;
      y1c       <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      color_reg <= '0;
      fb_x      <= '0;
      fb_y      <= '0;
      fb_color  <= '0;
      fb_write  <= 1'b0;
    end else begin
      fb_write <= 1'b0;
      if (cpu_write) begin
        fb_x     <= cpu_x;
        fb_y     <= cpu_y;
        fb_color <= cpu_color;
        fb_write <= 1'b1;
      end else if (issue) begin
        fb_x     <= cur_x;
        fb_y     <= cur_y;
        fb_color <= color_reg;
        fb_write <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fill_start) begin
            color_reg <= fill_color;
            x0_reg    <= fill_x0;
            x1c       <= (fill_x1 > XMAX) ? XMAX : fill_x1;
            y1c       <= (fill_y1 > YMAX) ? YMAX : fill_y1;
            cur_x     <= fill_x0;
            cur_y     <= fill_y0;
            state     <= empty ? DONE : FILL;
          end
        end
        FILL: begin
          if (abort) begin
            state <= DONE;
          end else if (issue) begin
            if (last) begin
              state <= DONE;
            end else if (cur_x == x1c) begin
              cur_x <= x0_reg;
              cur_y <= cur_y + 8'd1;
            end else begin
              cur_x <= cur_x + 8'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/framebuffer_fill_ctrl.md
Name: framebuffer_fill_ctrl

Overview:
- Write-side controller for the 160x120, 8-bit-per-pixel frame buffer.
- Shares the buffer's single write port (x, y, color, write) between the CPU's per-pixel store path and a rectangle fill/clear engine.
- CPU stores always win; the fill engine issues one pixel per free cycle, in row-major order, and stalls on cycles the CPU uses.
- Sits between the processor's store decode and the frame buffer's write port; the read/scan-out port is untouched.

Parameters:
- WIDTH, 160, pixels per row.
- HEIGHT, 120, rows.
- BITSPERPIXEL, 8, color width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cpu_x  in  8  CPU pixel column
- cpu_y  in  8  CPU pixel row
- cpu_color  in  BITSPERPIXEL  CPU pixel color
- cpu_write  in  1  CPU store strobe, one pixel per high cycle
- fill_start  in  1  start pulse; parameters sampled on the same cycle
- fill_x0  in  8  rectangle left column, inclusive
- fill_y0  in  8  rectangle top row, inclusive
- fill_x1  in  8  rectangle right column, inclusive
- fill_y1  in  8  rectangle bottom row, inclusive
- fill_color  in  BITSPERPIXEL  fill color
- fill_busy  out  1  fill engine active
- fill_done  out  1  one-cycle completion pulse
- fb_x  out  8  to frame buffer x
- fb_y  out  8  to frame buffer y
- fb_color  out  BITSPERPIXEL  to frame buffer color
- fb_write  out  1  to frame buffer write

Behaviour:
- Reset (rst high at a clk edge, any state, including mid-fill):
  - state to IDLE.
  - fb_write, fill_busy, fill_done, fb_x, fb_y, fb_color all 0.
  - In-progress fill abandoned; pixels already written stay written.
- Registered outputs: all fb_* outputs are registered, so latency is exactly 1 cycle from the cycle a write is chosen.
- Arbitration, evaluated every cycle:
  - If cpu_write=1: next cycle fb_* = {cpu_x, cpu_y, cpu_color, 1}. Coordinates are passed unmodified; out-of-range values are not filtered here.
  - Else if state=FILL: next cycle fb_* = {cur_x, cur_y, color_reg, 1}, and the cursor advances.
  - Else: next cycle fb_write=0; fb_x, fb_y and fb_color hold their previous values.
  - A FILL cycle with cpu_write=1 does not advance the cursor and loses no pixel.
- States:
  - IDLE: on fill_start=1, latch color and the rectangle.
    - Rectangle is empty if x0>x1, y0>y1, x0>=WIDTH or y0>=HEIGHT (raw input values).
    - Otherwise x1c=min(x1,WIDTH-1), y1c=min(y1,HEIGHT-1); cursor=(x0,y0).
    - Next state FILL, or DONE if empty.
  - FILL: fill_busy=1.
    - On each issued pixel: if cur_x==x1c, set cur_x=x0 and cur_y+=1; else cur_x+=1.
    - Issuing (x1c,y1c) moves the state to DONE.
    - fill_start is ignored while in FILL.
  - DONE: lasts 1 cycle. fill_done=1, fill_busy=0, then IDLE.
    - For a non-empty fill, the last fill pixel appears on fb_* in this same cycle.
    - fill_start in DONE is ignored.
- fill_busy:
  - Goes high the cycle after an accepted fill_start for a non-empty rectangle.
  - For an empty rectangle it stays 0; fill_done pulses the cycle after start.
- Timing and count:
  - Fill writes = (x1c-x0+1)*(y1c-y0+1).
  - Start-to-done cycles = writes + CPU writes during FILL + 1.
  - Full-screen clear = 19200 writes.
- Width rule: the cursor is 8 bits and never exceeds WIDTH-1/HEIGHT-1, so there is no wrap-around past 255.

Optional Feature:
- Macro FILL_ABORT_EN.
- Defined:
  - Adds input port fill_abort (1 bit).
  - fill_abort=1 in FILL: no further fill pixel is chosen from that cycle on; next state DONE, and fill_done pulses.
  - A CPU write in the same cycle is still issued.
  - fill_abort is ignored outside FILL.
- Undefined: the port does not exist; a fill always runs to completion unless rst is asserted.

Test Plan:
- Reset then idle: rst for 2 cycles -> all outputs 0; fb_write stays 0 with no requests.
- CPU passthrough: cpu_write=1, (10,20), color 0x3C -> next cycle fb_write=1, fb_x=10, fb_y=20, fb_color=0x3C.
- Small fill: start (2,3)-(4,4), color 0xAA -> 6 writes in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) on consecutive cycles; fill_done coincides with (4,4); fill_busy high for 6 cycles.
- Clip and empty cases:
  - (150,115)-(200,200) -> 10x5=50 writes, last (159,119).
  - (5,5)-(4,9) -> 0 writes; fill_done the cycle after start.
  - x0=160 -> 0 writes; fill_done the cycle after start.
- Contention: during a 4-pixel fill, cpu_write on fill cycles 2 and 3 -> CPU pixels appear in those slots, all 4 fill pixels still written, done 2 cycles later than uncontended.
- Reset mid-fill: full-screen fill, rst after 100 fill writes -> next cycle fb_write=0, fill_busy=0, no fill_done; a new fill_start is accepted afterwards.
